// File: rtl/tcp_app_rx_msg_pkg.sv
// rtl/tcp_app_rx_msg_pkg.sv - shared state encoding and helpers for the RX message scheduler
package tcp_app_rx_msg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_NOTIF_REQ  = 3'd1,
    ST_NOTIF_RESP = 3'd2,
    ST_RD_REQ     = 3'd3,
    ST_DATA       = 3'd4,
    ST_PTR_UPD    = 3'd5,
    ST_REQUEUE    = 3'd6
  } rx_sched_state_e;

  function automatic int pad_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned chunk_min(input int unsigned avail, input int unsigned max_chunk);
    return (avail < max_chunk) ? avail : max_chunk;
  endfunction

endpackage

// File: rtl/rx_msg_credit_cnt.sv
// rtl/rx_msg_credit_cnt.sv - saturating up/down counter of in-flight message credits
module rx_msg_credit_cnt #(
  parameter int MAX_CNT = 4,
  localparam int CNT_W = $clog2(MAX_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A return arriving at zero is spurious and dropped; inc+dec together cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && dec && (cnt_q != '0)) begin
      cnt_d = cnt_q;
    end else if (inc && !full) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign full = (cnt_q == CNT_W'(MAX_CNT));

endmodule

// File: rtl/tcp_app_rx_msg_sched.sv
// rtl/tcp_app_rx_msg_sched.sv - per-flow RX scheduler: query state, read a chunk, forward, commit, requeue
module tcp_app_rx_msg_sched
  import tcp_app_rx_msg_pkg::*;
#(
  parameter int FLOWID_W        = 8,
  parameter int PTR_W           = 16,
  parameter int DATA_W          = 512,
  parameter int MAX_CHUNK_BYTES = 1024,
  parameter int MAX_OUTSTANDING = 4,
  localparam int PAD_W          = pad_w(DATA_W),
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                aq_empty,
  output logic                aq_rd_req,
  input  logic [FLOWID_W-1:0] aq_rd_data,
  output logic                aq_wr_req,
  output logic [FLOWID_W-1:0] aq_wr_data,
  input  logic                aq_wr_rdy,
  output logic                notif_req_val,
  input  logic                notif_req_rdy,
  output logic [FLOWID_W-1:0] notif_req_flowid,
  input  logic                notif_resp_val,
  output logic                notif_resp_rdy,
  input  logic [PTR_W:0]      notif_resp_head,
  input  logic [PTR_W:0]      notif_resp_avail,
  output logic                rd_req_val,
  input  logic                rd_req_rdy,
  output logic [FLOWID_W-1:0] rd_req_flowid,
  output logic [PTR_W-1:0]    rd_req_offset,
  output logic [PTR_W:0]      rd_req_size,
  input  logic                rd_data_val,
  output logic                rd_data_rdy,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic                rd_data_last,
  input  logic [PAD_W-1:0]    rd_data_padbytes,
  output logic                msg_val,
  input  logic                msg_rdy,
  output logic [FLOWID_W-1:0] msg_flowid,
  output logic [DATA_W-1:0]   msg_data,
  output logic                msg_last,
  output logic [PAD_W-1:0]    msg_padbytes,
  output logic                ptr_upd_val,
  input  logic                ptr_upd_rdy,
  output logic [FLOWID_W-1:0] ptr_upd_flowid,
  output logic [PTR_W:0]      ptr_upd_head,
  input  logic                credit_ret,
  output logic [CNT_W-1:0]    outstanding
);

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    logic [PTR_W:0]      head;
  } ptr_upd_t;

  rx_sched_state_e     state_q, state_d;
  logic [FLOWID_W-1:0] flowid_q, flowid_d;
  logic [PTR_W:0]      head_q, head_d;
  logic [PTR_W:0]      chunk_q, chunk_d;
  logic                credits_full;
  logic                last_hs;
  ptr_upd_t            ptr_upd;

  assign last_hs = (state_q == ST_DATA) && rd_data_val && msg_rdy && rd_data_last;

  always_comb begin
    state_d  = state_q;
    flowid_d = flowid_q;
    head_d   = head_q;
    chunk_d  = chunk_q;
    unique case (state_q)
      ST_IDLE: if (aq_rd_req) begin
        flowid_d = aq_rd_data;
        state_d  = ST_NOTIF_REQ;
      end
      ST_NOTIF_REQ:  if (notif_req_rdy) state_d = ST_NOTIF_RESP;
      ST_NOTIF_RESP: if (notif_resp_val) begin
        head_d  = notif_resp_head;
        chunk_d = (PTR_W+1)'(chunk_min(32'(notif_resp_avail), MAX_CHUNK_BYTES));
        // Nothing to read: skip straight to requeue without consuming a credit.
        state_d = (notif_resp_avail == '0) ? ST_REQUEUE : ST_RD_REQ;
      end
      ST_RD_REQ:  if (rd_req_rdy) state_d = ST_DATA;
      ST_DATA:    if (last_hs) state_d = ST_PTR_UPD;
      ST_PTR_UPD: if (ptr_upd_rdy) state_d = ST_REQUEUE;
      ST_REQUEUE: if (aq_wr_rdy) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      flowid_q <= '0;
      head_q   <= '0;
      chunk_q  <= '0;
    end else begin
      state_q  <= state_d;
      flowid_q <= flowid_d;
      head_q   <= head_d;
      chunk_q  <= chunk_d;
    end
  end

  rx_msg_credit_cnt #(.MAX_CNT(MAX_OUTSTANDING)) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (last_hs),
    .dec   (credit_ret),
    .cnt   (outstanding),
    .full  (credits_full)
  );

  assign aq_rd_req        = (state_q == ST_IDLE) && !aq_empty && !credits_full;
  assign aq_wr_req        = (state_q == ST_REQUEUE);
  assign aq_wr_data       = flowid_q;
  assign notif_req_val    = (state_q == ST_NOTIF_REQ);
  assign notif_req_flowid = flowid_q;
  assign notif_resp_rdy   = (state_q == ST_NOTIF_RESP);
  assign rd_req_val       = (state_q == ST_RD_REQ);
  assign rd_req_flowid    = flowid_q;
  assign rd_req_offset    = head_q[PTR_W-1:0];
  assign rd_req_size      = chunk_q;

  // Payload is a pure pass-through so the reader sees the TX side's backpressure directly.
  assign msg_val      = (state_q == ST_DATA) && rd_data_val;
  assign rd_data_rdy  = (state_q == ST_DATA) && msg_rdy;
  assign msg_flowid   = flowid_q;
  assign msg_data     = rd_data;
  assign msg_last     = rd_data_last;
  assign msg_padbytes = rd_data_padbytes;

  assign ptr_upd.flowid = flowid_q;
  assign ptr_upd.head   = head_q + chunk_q;
  assign ptr_upd_val    = (state_q == ST_PTR_UPD);
  assign ptr_upd_flowid = ptr_upd.flowid;
  assign ptr_upd_head   = ptr_upd.head;

endmodule

// File: tb/tb_tcp_app_rx_msg_sched.sv
// tb/tb_tcp_app_rx_msg_sched.sv - self-checking bench for tcp_app_rx_msg_sched
module tb_tcp_app_rx_msg_sched;

  localparam int FW = 8;
  localparam int PW = 16;
  localparam int DW = 512;
  localparam int PADW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic aq_empty = 1'b1, aq_rd_req, aq_wr_req, aq_wr_rdy = 1'b0;
  logic [FW-1:0] aq_rd_data = '0, aq_wr_data;
  logic notif_req_val, notif_req_rdy = 1'b0, notif_resp_val = 1'b0, notif_resp_rdy;
  logic [FW-1:0] notif_req_flowid;
  logic [PW:0] notif_resp_head = '0, notif_resp_avail = '0;
  logic rd_req_val, rd_req_rdy = 1'b0;
  logic [FW-1:0] rd_req_flowid;
  logic [PW-1:0] rd_req_offset;
  logic [PW:0] rd_req_size;
  logic rd_data_val = 1'b0, rd_data_rdy, rd_data_last = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic [PADW-1:0] rd_data_padbytes = '0;
  logic msg_val, msg_rdy = 1'b0, msg_last;
  logic [FW-1:0] msg_flowid;
  logic [DW-1:0] msg_data;
  logic [PADW-1:0] msg_padbytes;
  logic ptr_upd_val, ptr_upd_rdy = 1'b0;
  logic [FW-1:0] ptr_upd_flowid;
  logic [PW:0] ptr_upd_head;
  logic credit_ret = 1'b0;
  logic [1:0] outstanding;

  tcp_app_rx_msg_sched #(
    .FLOWID_W(FW), .PTR_W(PW), .DATA_W(DW), .MAX_CHUNK_BYTES(1024), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .aq_empty(aq_empty), .aq_rd_req(aq_rd_req), .aq_rd_data(aq_rd_data),
    .aq_wr_req(aq_wr_req), .aq_wr_data(aq_wr_data), .aq_wr_rdy(aq_wr_rdy),
    .notif_req_val(notif_req_val), .notif_req_rdy(notif_req_rdy), .notif_req_flowid(notif_req_flowid),
    .notif_resp_val(notif_resp_val), .notif_resp_rdy(notif_resp_rdy),
    .notif_resp_head(notif_resp_head), .notif_resp_avail(notif_resp_avail),
    .rd_req_val(rd_req_val), .rd_req_rdy(rd_req_rdy), .rd_req_flowid(rd_req_flowid),
    .rd_req_offset(rd_req_offset), .rd_req_size(rd_req_size),
    .rd_data_val(rd_data_val), .rd_data_rdy(rd_data_rdy), .rd_data(rd_data),
    .rd_data_last(rd_data_last), .rd_data_padbytes(rd_data_padbytes),
    .msg_val(msg_val), .msg_rdy(msg_rdy), .msg_flowid(msg_flowid), .msg_data(msg_data),
    .msg_last(msg_last), .msg_padbytes(msg_padbytes),
    .ptr_upd_val(ptr_upd_val), .ptr_upd_rdy(ptr_upd_rdy), .ptr_upd_flowid(ptr_upd_flowid),
    .ptr_upd_head(ptr_upd_head), .credit_ret(credit_ret), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] flowid;
    logic [PW:0]   head;
    logic [PW:0]   avail;
    logic [PW-1:0] exp_off;
    logic [PW:0]   exp_size;
    logic [PW:0]   exp_ptr;
    int            exp_beats;
    bit            exp_rd;
    int            rnd;
  } vec_t;

  typedef struct { logic [FW-1:0] flowid; logic [PW-1:0] off; logic [PW:0] size; } rd_ent_t;
  typedef struct { logic [FW-1:0] flowid; logic [PW:0] head; } ptr_ent_t;
  typedef struct { logic [FW-1:0] flowid; logic [DW-1:0] data; logic last; logic [PADW-1:0] pad; } beat_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats = 0;
  int rd_sent = 0;
  int pops = 0;
  int resp_cyc = 0;
  int rq_cyc = 0;
  int rdy_mode = 0;
  bit cr_req = 1'b0;
  bit rst_req = 1'b1;

  logic [FW-1:0] aq_q[$];
  logic [PW:0] head_mem[256];
  logic [PW:0] avail_mem[256];
  rd_ent_t rd_log[$];
  ptr_ent_t ptr_log[$];
  logic [FW-1:0] rq_log[$];
  beat_t exp_msg[$];

  logic [FW-1:0] cur_flow = '0;
  bit resp_pend = 1'b0;
  logic [PW:0] resp_head = '0, resp_avail = '0;
  logic [FW-1:0] rd_flow = '0;
  int rd_size = 0, rd_total = 0, rd_idx = 0, rd_rem = 0, rd_seq = 0;
  bit pv_hold = 1'b0;
  logic [PW:0] pv_head = '0;

  function automatic logic [DW-1:0] beat_data(input logic [FW-1:0] f, input int idx, input int seq);
    logic [31:0] w;
    w = {f, 8'(idx), 16'(seq)};
    return {16{w}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Environment: active queue, notification engine, buffer reader and TX sink.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      rst_n = !rst_req;
      credit_ret = cr_req;
      cr_req = 1'b0;
      if (!rst_n) begin
        rd_rem = 0;
        resp_pend = 1'b0;
        pv_hold = 1'b0;
        exp_msg.delete();
      end
      aq_empty = (aq_q.size() == 0);
      aq_rd_data = aq_empty ? '0 : aq_q[0];
      aq_wr_rdy = (rdy_mode != 1) || ($urandom_range(0, 2) != 0);
      notif_req_rdy = 1'b1;
      notif_resp_val = resp_pend;
      notif_resp_head = resp_head;
      notif_resp_avail = resp_avail;
      rd_req_rdy = (rd_rem == 0) && ((rdy_mode != 1) || ($urandom_range(0, 1) == 1));
      rd_data_val = (rd_rem > 0);
      rd_data = beat_data(rd_flow, rd_idx, rd_seq);
      rd_data_last = (rd_rem == 1);
      rd_data_padbytes = (rd_rem == 1) ? PADW'(rd_total * 64 - rd_size) : '0;
      msg_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      ptr_upd_rdy = (rdy_mode != 1) || ($urandom_range(0, 1) == 1);
      #1;
      if (rst_n) begin
        if (pv_hold) begin
          checks++;
          if (!(ptr_upd_val && ptr_upd_head == pv_head)) begin
            errors++;
            $display("FAIL ptr_upd_hold: val %0b head 0x%0h expected held 0x%0h", ptr_upd_val, ptr_upd_head, pv_head);
          end
        end
        pv_hold = ptr_upd_val && !ptr_upd_rdy;
        pv_head = ptr_upd_head;
        if (aq_rd_req && aq_q.size() > 0) begin
          pops++;
          cur_flow = aq_q.pop_front();
        end
        if (notif_resp_val && notif_resp_rdy) begin
          resp_pend = 1'b0;
          resp_cyc = cyc;
        end
        if (notif_req_val && notif_req_rdy) begin
          resp_pend = 1'b1;
          resp_head = head_mem[notif_req_flowid];
          resp_avail = avail_mem[notif_req_flowid];
        end
        if (rd_data_val && rd_data_rdy) begin
          rd_idx++;
          rd_rem--;
          rd_sent++;
        end
        if (msg_val && msg_rdy) begin
          beats++;
          checks++;
          if (exp_msg.size() == 0) begin
            errors++;
            $display("FAIL sb_extra_beat: flowid %0d last %0b", msg_flowid, msg_last);
          end else begin
            e = exp_msg.pop_front();
            if ({msg_flowid, msg_data, msg_last, msg_padbytes} !== {e.flowid, e.data, e.last, e.pad}) begin
              errors++;
              $display("FAIL sb_beat: got flow %0d last %0b pad %0d w0 0x%0h, expected flow %0d last %0b pad %0d w0 0x%0h",
                       msg_flowid, msg_last, msg_padbytes, msg_data[31:0], e.flowid, e.last, e.pad, e.data[31:0]);
            end
          end
        end
        if (rd_req_val && rd_req_rdy) begin
          rd_log.push_back('{rd_req_flowid, rd_req_offset, rd_req_size});
          rd_seq++;
          rd_flow = rd_req_flowid;
          rd_size = int'(rd_req_size);
          rd_total = (rd_size + 63) / 64;
          rd_rem = rd_total;
          rd_idx = 0;
          for (int i = 0; i < rd_total; i++) begin
            e.flowid = cur_flow;
            e.data = beat_data(rd_req_flowid, i, rd_seq);
            e.last = (i == rd_total - 1);
            e.pad = e.last ? PADW'(rd_total * 64 - rd_size) : '0;
            exp_msg.push_back(e);
          end
        end
        if (ptr_upd_val && ptr_upd_rdy) ptr_log.push_back('{ptr_upd_flowid, ptr_upd_head});
        if (aq_wr_req && aq_wr_rdy) begin
          rq_log.push_back(aq_wr_data);
          rq_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic credit_pulse();
    cr_req = 1'b1;
    step(2);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_outstanding"}, 64'(outstanding), 0);
    chk({tag, "_aq_rd_req"}, 64'(aq_rd_req), 0);
    chk({tag, "_aq_wr_req"}, 64'(aq_wr_req), 0);
    chk({tag, "_notif_req_val"}, 64'(notif_req_val), 0);
    chk({tag, "_notif_resp_rdy"}, 64'(notif_resp_rdy), 0);
    chk({tag, "_rd_req_val"}, 64'(rd_req_val), 0);
    chk({tag, "_rd_data_rdy"}, 64'(rd_data_rdy), 0);
    chk({tag, "_msg_val"}, 64'(msg_val), 0);
    chk({tag, "_ptr_upd_val"}, 64'(ptr_upd_val), 0);
  endtask

  int exp_out = 0;

  task automatic run_vec(input vec_t v, input bit ret_credit);
    int n;
    int b0;
    head_mem[v.flowid] = v.head;
    avail_mem[v.flowid] = v.avail;
    rd_log.delete();
    ptr_log.delete();
    rq_log.delete();
    b0 = beats;
    rdy_mode = v.rnd;
    aq_q.push_back(v.flowid);
    n = 0;
    while (rq_log.size() == 0 && n < 400) begin
      step(1);
      n++;
    end
    chk($sformatf("f%0d_requeued", v.flowid), 64'(rq_log.size()), 1);
    if (rq_log.size() > 0) chk($sformatf("f%0d_requeue_id", v.flowid), 64'(rq_log[0]), 64'(v.flowid));
    chk($sformatf("f%0d_rd_count", v.flowid), 64'(rd_log.size()), 64'(v.exp_rd));
    chk($sformatf("f%0d_ptr_count", v.flowid), 64'(ptr_log.size()), 64'(v.exp_rd));
    chk($sformatf("f%0d_beats", v.flowid), 64'(beats - b0), 64'(v.exp_beats));
    chk($sformatf("f%0d_sb_drained", v.flowid), 64'(exp_msg.size()), 0);
    if (v.exp_rd && rd_log.size() > 0) begin
      chk($sformatf("f%0d_rd_flowid", v.flowid), 64'(rd_log[0].flowid), 64'(v.flowid));
      chk($sformatf("f%0d_rd_offset", v.flowid), 64'(rd_log[0].off), 64'(v.exp_off));
      chk($sformatf("f%0d_rd_size", v.flowid), 64'(rd_log[0].size), 64'(v.exp_size));
    end
    if (v.exp_rd && ptr_log.size() > 0) begin
      chk($sformatf("f%0d_ptr_flowid", v.flowid), 64'(ptr_log[0].flowid), 64'(v.flowid));
      chk($sformatf("f%0d_ptr_head", v.flowid), 64'(ptr_log[0].head), 64'(v.exp_ptr));
    end
    if (!v.exp_rd) chk($sformatf("f%0d_skip_latency_le4", v.flowid), 64'((rq_cyc - resp_cyc) <= 4), 1);
    if (v.exp_rd) exp_out++;
    chk($sformatf("f%0d_outstanding", v.flowid), 64'(outstanding), 64'(exp_out));
    if (ret_credit && v.exp_rd) begin
      credit_pulse();
      exp_out--;
      chk($sformatf("f%0d_credit_back", v.flowid), 64'(outstanding), 64'(exp_out));
    end
    rdy_mode = 0;
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    int n;
    int b0;
    int r0;
    int p0;
    vecs[0] = '{8'd3, 17'h00010, 17'd100,  16'h0010, 17'd100,  17'h00074, 2,  1'b1, 0};
    vecs[1] = '{8'd5, 17'h00200, 17'd3000, 16'h0200, 17'd1024, 17'h00600, 16, 1'b1, 1};
    vecs[2] = '{8'd5, 17'h00600, 17'd1976, 16'h0600, 17'd1024, 17'h00A00, 16, 1'b1, 0};
    vecs[3] = '{8'd7, 17'h00123, 17'd0,    16'h0000, 17'd0,    17'h00000, 0,  1'b0, 0};
    vecs[4] = '{8'd9, 17'h1FFF0, 17'h40,   16'hFFF0, 17'h40,   17'h00030, 1,  1'b1, 0};
    vecs[5] = '{8'd1, 17'h0FFFF, 17'd1,    16'hFFFF, 17'd1,    17'h10000, 1,  1'b1, 1};
    vecs[6] = '{8'd2, 17'h00000, 17'd1024, 16'h0000, 17'd1024, 17'h00400, 16, 1'b1, 0};
    vecs[7] = '{8'd4, 17'h1FC00, 17'd1025, 16'hFC00, 17'd1024, 17'h00000, 16, 1'b1, 1};

    step(3);
    check_idle("reset");
    rst_req = 1'b0;
    step(2);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b1);

    // Credit limit: two messages in flight block the third pop until a credit returns.
    rq_log.delete();
    p0 = pops;
    for (int f = 10; f < 13; f++) begin
      head_mem[f] = '0;
      avail_mem[f] = 17'd64;
      aq_q.push_back(8'(f));
    end
    n = 0;
    while (rq_log.size() < 2 && n < 400) begin
      step(1);
      n++;
    end
    step(8);
    chk("cred_two_served", 64'(rq_log.size()), 2);
    chk("cred_pops", 64'(pops - p0), 2);
    chk("cred_third_waiting", 64'(aq_q.size()), 1);
    chk("cred_outstanding_full", 64'(outstanding), 2);
    chk("cred_aq_rd_req_withheld", 64'(aq_rd_req), 0);
    rdy_mode = 2;
    credit_pulse();
    chk("cred_after_ret", 64'(outstanding), 1);
    n = 0;
    while (!msg_val && n < 100) begin
      step(1);
      n++;
    end
    chk("cred_third_data", 64'(msg_val), 1);
    rdy_mode = 0;
    cr_req = 1'b1;
    n = 0;
    while (rq_log.size() < 3 && n < 100) begin
      step(1);
      n++;
    end
    chk("cred_third_requeued", 64'(rq_log.size()), 3);
    if (rq_log.size() > 2) chk("cred_third_id", 64'(rq_log[2]), 12);
    chk("cred_coincident_unchanged", 64'(outstanding), 1);
    credit_pulse();
    chk("cred_drain", 64'(outstanding), 0);
    credit_pulse();
    chk("cred_saturate_zero", 64'(outstanding), 0);
    exp_out = 0;

    // Reset in the middle of a burst with random TX backpressure.
    v = '{8'd19, 17'h00000, 17'd64, 16'h0000, 17'd64, 17'h00040, 1, 1'b1, 0};
    run_vec(v, 1'b0);
    ptr_log.delete();
    head_mem[20] = '0;
    avail_mem[20] = 17'd1024;
    b0 = beats;
    r0 = rd_sent;
    rdy_mode = 1;
    aq_q.push_back(8'd20);
    n = 0;
    while (beats < b0 + 5 && n < 400) begin
      step(1);
      n++;
    end
    chk("rst_midburst_reached", 64'(beats >= b0 + 5), 1);
    rst_req = 1'b1;
    step(3);
    check_idle("in_reset");
    chk("rst_beats_match_reader", 64'(beats - b0), 64'(rd_sent - r0));
    chk("rst_no_ptr_upd", 64'(ptr_log.size()), 0);
    rst_req = 1'b0;
    rdy_mode = 0;
    exp_out = 0;
    step(3);
    check_idle("after_reset");
    v = '{8'd21, 17'h00040, 17'd100, 16'h0040, 17'd100, 17'h000A4, 2, 1'b1, 0};
    run_vec(v, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
